// File: rtl/data_pipe_pkg.sv
// Shared types and helpers for the data_pipe retiming pipeline.
// Stage control is decoded once per cycle and fanned out to every stage.
package data_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ADV   = 2'd3
    } stage_ctrl_e;

    // Width needed to hold an occupancy value of 0..depth inclusive.
    function automatic int cw(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Priority: rst > flush > stall > advance.
    function automatic stage_ctrl_e decode_ctrl(input logic rst,
                                                input logic flush,
                                                input logic stall);
        stage_ctrl_e c;
        if (rst)        c = ST_RESET;
        else if (flush) c = ST_FLUSH;
        else if (stall) c = ST_HOLD;
        else            c = ST_ADV;
        return c;
    endfunction

endpackage

// File: rtl/data_pipe_stage.sv
// One pipeline stage: a valid bit plus a data register, steered by the shared stage control.
// The data register only clears when RESET_DATA is set; the valid bit always clears.
module pipe_stage
    import data_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter bit               RESET_DATA = 1'b1
) (
    input  logic             clk,
    input  stage_ctrl_e      ctrl,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v_q,
    output logic [WIDTH-1:0] d_q
);

    logic             v_d;
    logic [WIDTH-1:0] d_d;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        case (ctrl)
            ST_RESET, ST_FLUSH: begin
                v_d = 1'b0;
                if (RESET_DATA) d_d = RST_VAL;
            end
            ST_ADV: begin
                // Data follows the chain even for bubbles; no valid gating.
                v_d = v_in;
                d_d = d_in;
            end
            default: begin
                v_d = v_q;
                d_d = d_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        v_q <= v_d;
        d_q <= d_d;
    end

endmodule

// File: rtl/data_pipe.sv
// Fixed-latency register pipeline with per-stage valid, global stall, flush and occupancy count.
// Latency is DEPTH-1 edges from acceptance to visibility at the output stage.
module data_pipe
    import data_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      DEPTH      = 4,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter bit               RESET_DATA = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [cw(DEPTH)-1:0]   count
);

    localparam int CW = cw(DEPTH);

    stage_ctrl_e      ctrl;
    logic [DEPTH-1:0] v_chain;
    logic [WIDTH-1:0] d_chain [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    always_comb begin
        ctrl = decode_ctrl(rst, flush, stall);
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            pipe_stage #(
                .WIDTH      (WIDTH),
                .RST_VAL    (RST_VAL),
                .RESET_DATA (RESET_DATA)
            ) u_stage (
                .clk  (clk),
                .ctrl (ctrl),
                .v_in (in_valid),
                .d_in (in_data),
                .v_q  (v_chain[k]),
                .d_q  (d_chain[k])
            );
        end else begin : g_body
            pipe_stage #(
                .WIDTH      (WIDTH),
                .RST_VAL    (RST_VAL),
                .RESET_DATA (RESET_DATA)
            ) u_stage (
                .clk  (clk),
                .ctrl (ctrl),
                .v_in (v_chain[k-1]),
                .d_in (d_chain[k-1]),
                .v_q  (v_chain[k]),
                .d_q  (d_chain[k])
            );
        end
    end

    // Occupancy tracks popcount of the valid chain incrementally: one in, one out per advance.
    always_comb begin
        count_d = count_q;
        case (ctrl)
            ST_RESET, ST_FLUSH: count_d = '0;
            ST_ADV:             count_d = count_q + CW'(in_valid) - CW'(v_chain[DEPTH-1]);
            default:            count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign in_ready  = ~stall;
    assign out_valid = v_chain[DEPTH-1];
    assign out_data  = d_chain[DEPTH-1];
    assign count     = count_q;

endmodule

// File: tb/tb_data_pipe.sv
// Bench for data_pipe: three builds (DEPTH=4 with/without data reset, DEPTH=1) on shared stimulus,
// checked each cycle against a history-of-advances model plus directed literal expectations.
module tb_data_pipe;

    localparam logic [7:0] RV = 8'hC3;

    logic       clk = 1'b0;
    logic       rst, in_valid, stall, flush;
    logic [7:0] in_data;

    logic       ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
    logic [7:0] od_a, od_b, od_c;
    logic [2:0] cnt_a, cnt_b;
    logic [0:0] cnt_c;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    data_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(RV), .RESET_DATA(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .stall(stall),
        .flush(flush), .in_ready(ir_a), .out_valid(ov_a), .out_data(od_a), .count(cnt_a));
    data_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(RV), .RESET_DATA(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .stall(stall),
        .flush(flush), .in_ready(ir_b), .out_valid(ov_b), .out_data(od_b), .count(cnt_b));
    data_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(RV), .RESET_DATA(1'b1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .stall(stall),
        .flush(flush), .in_ready(ir_c), .out_valid(ov_c), .out_data(od_c), .count(cnt_c));

    // Model: every advancing edge appends (valid, data, epoch); rst/flush start a new epoch.
    // The output stage holds the DEPTH-th most recent advance; it is valid only if that
    // advance happened in the current epoch.
    typedef struct {
        bit         v;
        logic [7:0] d;
        int         ep;
    } rec_t;

    typedef struct {
        bit         v;
        int         cnt;
        logic [7:0] d;
        bit         dk;
    } exp_t;

    rec_t hist[$];
    int   epoch = 0;

    always @(posedge clk) begin
        if (rst || flush) epoch++;
        else if (!stall) hist.push_back('{v: in_valid, d: in_data, ep: epoch});
    end

    function automatic exp_t exp_of(input int d, input bit rd);
        exp_t e;
        rec_t r;
        int   n;
        n     = hist.size();
        e.v   = 1'b0;
        e.cnt = 0;
        e.d   = RV;
        e.dk  = rd;
        for (int k = 1; k <= d && k <= n; k++) begin
            r = hist[n-k];
            if (r.ep == epoch && r.v) e.cnt++;
        end
        if (n >= d) begin
            r    = hist[n-d];
            e.v  = (r.ep == epoch) && r.v;
            e.dk = 1'b1;
            if (rd) e.d = (r.ep == epoch) ? r.d : RV;
            else    e.d = r.d;
        end
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            e = exp_of(4, 1'b1);
            check("a_valid", int'(ov_a), int'(e.v));
            check("a_count", int'(cnt_a), e.cnt);
            if (e.dk) check("a_data", int'(od_a), int'(e.d));
            e = exp_of(4, 1'b0);
            check("b_valid", int'(ov_b), int'(e.v));
            check("b_count", int'(cnt_b), e.cnt);
            if (e.dk) check("b_data", int'(od_b), int'(e.d));
            e = exp_of(1, 1'b1);
            check("c_valid", int'(ov_c), int'(e.v));
            check("c_count", int'(cnt_c), e.cnt);
            if (e.dk) check("c_data", int'(od_c), int'(e.d));
            check("in_ready", int'({ir_a, ir_b, ir_c}), stall ? 0 : 7);
        end
    end

    task automatic cyc(input bit v, input logic [7:0] d,
                       input bit st = 1'b0, input bit fl = 1'b0, input bit r = 1'b0);
        in_valid = v;
        in_data  = d;
        stall    = st;
        flush    = fl;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset with garbage on every other input
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE; stall = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        cyc(1'b1, 8'h5E, 1'b1, 1'b0, 1'b1);
        check("t1_valid", int'(ov_a), 0);
        check("t1_count", int'(cnt_a), 0);
        check("t1_data", int'(od_a), 'hC3);
        check("t1_data_d1", int'(od_c), 'hC3);

        // 2: streaming 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 8'(i));
            if (i < 4) begin
                check("t2_count_ramp", int'(cnt_a), i);
                check("t2_valid_early", int'(ov_a), 0);
            end else begin
                check("t2_count_full", int'(cnt_a), 4);
                check("t2_valid", int'(ov_a), 1);
                check("t2_data", int'(od_a), i - 3);
            end
            check("t2_data_d1", int'(od_c), i);
        end
        check("t2_first_after_fill", int'(od_b), 5);
        repeat (4) cyc(1'b0, 8'h00);
        check("t2_drained", int'(cnt_a), 0);

        // 3: stall with three beats in flight
        cyc(1'b1, 8'h11);
        cyc(1'b1, 8'h22);
        cyc(1'b1, 8'h33);
        check("t3_count", int'(cnt_a), 3);
        repeat (3) begin
            cyc(1'b1, 8'h99, 1'b1);
            check("t3_hold_count", int'(cnt_a), 3);
            check("t3_hold_valid", int'(ov_a), 0);
        end
        cyc(1'b0, 8'h00);
        check("t3_out11", int'(od_a), 'h11);
        check("t3_out11_v", int'(ov_a), 1);
        cyc(1'b0, 8'h00, 1'b1);
        check("t3_hold11", int'(od_a), 'h11);
        check("t3_hold11_cnt", int'(cnt_a), 3);
        cyc(1'b0, 8'h00);
        check("t3_out22", int'(od_a), 'h22);
        check("t3_cnt2", int'(cnt_a), 2);
        cyc(1'b0, 8'h00);
        check("t3_out33", int'(od_a), 'h33);
        cyc(1'b0, 8'h00);
        check("t3_empty", int'(cnt_a), 0);

        // 4: bubbles 1,0,1,1,0
        cyc(1'b1, 8'hA0);
        cyc(1'b0, 8'hA1);
        cyc(1'b1, 8'hA2);
        cyc(1'b1, 8'hA3);
        check("t4_outA0", int'(od_a), 'hA0);
        check("t4_cntA0", int'(cnt_a), 3);
        cyc(1'b0, 8'hA4);
        check("t4_bubble_v", int'(ov_a), 0);
        check("t4_bubble_data", int'(od_a), 'hA1);
        check("t4_bubble_cnt", int'(cnt_a), 2);
        cyc(1'b0, 8'h00);
        check("t4_outA2", int'(od_a), 'hA2);
        cyc(1'b0, 8'h00);
        check("t4_outA3", int'(od_a), 'hA3);
        check("t4_cntA3", int'(cnt_a), 1);
        repeat (2) cyc(1'b0, 8'h00);

        // 5: flush beats stall on a full pipe
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h31 + i));
        check("t5_full", int'(cnt_a), 4);
        check("t5_out31", int'(od_a), 'h31);
        cyc(1'b1, 8'hFF, 1'b1, 1'b1);
        check("t5_flush_cnt", int'(cnt_a), 0);
        check("t5_flush_v", int'(ov_a), 0);
        check("t5_flush_data", int'(od_a), 'hC3);
        check("t5_flush_keep_b", int'(od_b), 'h31);
        repeat (4) cyc(1'b0, 8'h00);

        // 6: reset mid-stream; data-no-reset build keeps its output data
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h41 + i));
        check("t6_pre_b", int'(od_b), 'h42);
        cyc(1'b1, 8'h47, 1'b0, 1'b0, 1'b1);
        check("t6_rst_v", int'(ov_b), 0);
        check("t6_rst_cnt", int'(cnt_b), 0);
        check("t6_rst_data_b", int'(od_b), 'h42);
        check("t6_rst_data_a", int'(od_a), 'hC3);
        cyc(1'b1, 8'h5A);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        check("t6_lat_v", int'(ov_b), 0);
        cyc(1'b0, 8'h00);
        check("t6_out5A_v", int'(ov_b), 1);
        check("t6_out5A", int'(od_b), 'h5A);
        cyc(1'b0, 8'h00);
        check("t6_end_cnt", int'(cnt_b), 0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
